load_unit: RTL and testbench

Memory-stage load engine: accepts one load from the pipeline, drives a single read transaction on the data-bus request/response interface, extracts the addressed byte/half/word/double from the returned 64-bit beat, sign- or zero-extends it, and holds the result until the pipeline takes it. It is the read-direction counterpart of the store-side lane/strobe alignment logic. It sits between the memory-stage control and the dcache port. It supports pipeline flush while a bus transaction is outstanding.

---
 rtl/load_unit_pkg.sv | 39 +++
 rtl/load_unit_readdata.sv | 36 +++
 rtl/load_unit.sv | 157 +++++++++++++++
 tb/tb_load_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared types for the load unit slice.
//   u64 / u3      - common data/address and lane-index types
//   msize_t       - memory access size (byte/half/word/double)
//   load_state_t  - load_unit FSM states
//   is_misaligned - natural-alignment check for a given size and byte offset
package load_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [2:0]  u3;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } load_state_t;

  // An access is misaligned when any offset bit below its size is set.
  function automatic logic is_misaligned(input msize_t msize, input u3 offs);
    logic mis;
    case (msize)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = offs[0];
      MSIZE4:  mis = (offs[1:0] != 2'b00);
      MSIZE8:  mis = (offs != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_readdata.sv
// readdata: pick the addressed field out of a 64-bit aligned read beat and
// sign- or zero-extend it to 64 bits.
//   i_addr     - byte offset within the beat
//   i_msize    - access size
//   i_unsigned - zero-extend instead of sign-extend (ignored for MSIZE8)
//   i_data     - 64-bit aligned beat from the bus
//   o_data     - extended load value
module readdata
  import load_unit_pkg::*;
(
  input  u3      i_addr,
  input  msize_t i_msize,
  input  logic   i_unsigned,
  input  u64     i_data,
  output u64     o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  // Field selection by lane and extension by size.
  always_comb begin
    w_byte = i_data[{i_addr, 3'b000} +: 8];
    w_half = i_data[{i_addr[2:1], 4'b0000} +: 16];
    w_word = i_data[{i_addr[2], 5'b00000} +: 32];
    case (i_msize)
      MSIZE1:  o_data = i_unsigned ? {56'd0, w_byte} : {{56{w_byte[7]}}, w_byte};
      MSIZE2:  o_data = i_unsigned ? {48'd0, w_half} : {{48{w_half[15]}}, w_half};
      MSIZE4:  o_data = i_unsigned ? {32'd0, w_word} : {{32{w_word[31]}}, w_word};
      MSIZE8:  o_data = i_data;
      default: o_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: memory-stage load engine. Accepts one load, issues a single
// 64-bit aligned read on the dcache port, extracts/extends the result and
// holds it until the pipeline consumes it. A flush kills the load; a bus
// transaction already launched is still completed and its data swallowed.
//   clk, reset (async, active-high), flush
//   req_*   - load request from the pipeline (valid/ready, addr, size, unsigned)
//   dreq_*  - bus read request (valid, aligned addr, size)
//   dresp_* - bus response (addr_ok, data_ok, data)
//   resp_*  - registered result to the pipeline (valid/ready, data, misalign)
module load_unit
  import load_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   req_valid,
  output logic   req_ready,
  input  u64     req_addr,
  input  msize_t req_msize,
  input  logic   req_unsigned,
  output logic   dreq_valid,
  output u64     dreq_addr,
  output msize_t dreq_size,
  input  logic   dresp_addr_ok,
  input  logic   dresp_data_ok,
  input  u64     dresp_data,
  output logic   resp_valid,
  input  logic   resp_ready,
  output u64     resp_data,
  output logic   resp_misalign
);

  load_state_t r_state;
  load_state_t w_next;
  u3           r_lane;
  msize_t      r_msize;
  logic        r_unsigned;
  u64          r_dreq_addr;
  logic        r_killed;
  logic        r_resp_valid;
  u64          r_resp_data;
  logic        r_resp_misalign;
  logic        w_accept;
  logic        w_misalign;
  logic        w_kill;
  logic        w_capture;
  u64          w_ext;

  readdata u_readdata (
    .i_addr     (r_lane),
    .i_msize    (r_msize),
    .i_unsigned (r_unsigned),
    .i_data     (dresp_data),
    .o_data     (w_ext)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic. A flush seen in REQ before addr_ok is remembered in
  // r_killed so the handshake can finish before the result is dropped.
  always_comb begin
    w_next = r_state;
    w_kill = flush | r_killed;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_misalign ? S_DONE : S_REQ;
        else          w_next = S_IDLE;
      end
      S_REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) w_next = w_kill ? S_IDLE : S_DONE;
          else               w_next = w_kill ? S_DRAIN : S_WAIT;
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT: begin
        // Flush coinciding with data_ok has nothing left to drain.
        if (flush)              w_next = dresp_data_ok ? S_IDLE : S_DRAIN;
        else if (dresp_data_ok) w_next = S_DONE;
        else                    w_next = S_WAIT;
      end
      S_DONE: begin
        if (flush || resp_ready) w_next = S_IDLE;
        else                     w_next = S_DONE;
      end
      S_DRAIN: begin
        if (dresp_data_ok) w_next = S_IDLE;
        else               w_next = S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Decoded outputs and handshake strobes.
  always_comb begin
    req_ready  = (r_state == S_IDLE) && !flush;
    w_accept   = req_valid && req_ready;
    w_misalign = is_misaligned(req_msize, req_addr[2:0]);
    dreq_valid = (r_state == S_REQ);
    dreq_addr  = r_dreq_addr;
    dreq_size  = MSIZE8;
    w_capture  = (w_next == S_DONE) && ((r_state == S_REQ) || (r_state == S_WAIT));
  end

  // Request latches, captured on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane      <= 3'd0;
      r_msize     <= MSIZE1;
      r_unsigned  <= 1'b0;
      r_dreq_addr <= 64'd0;
    end else if (w_accept) begin
      r_lane      <= req_addr[2:0];
      r_msize     <= req_msize;
      r_unsigned  <= req_unsigned;
      r_dreq_addr <= {req_addr[63:3], 3'b000};
    end
  end

  // Pending-flush flag, only meaningful while the request is on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_killed <= 1'b0;
    else if (r_state == S_REQ) r_killed <= r_killed | flush;
    else                       r_killed <= 1'b0;
  end

  // Registered response; data/misalign cleared once the result is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid    <= 1'b0;
      r_resp_data     <= 64'd0;
      r_resp_misalign <= 1'b0;
    end else begin
      r_resp_valid <= (w_next == S_DONE);
      if (w_accept && w_misalign) begin
        r_resp_data     <= 64'd0;
        r_resp_misalign <= 1'b1;
      end else if (w_capture) begin
        r_resp_data     <= w_ext;
        r_resp_misalign <= 1'b0;
      end else if ((r_state == S_DONE) && (w_next == S_IDLE)) begin
        r_resp_data     <= 64'd0;
        r_resp_misalign <= 1'b0;
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign resp_misalign = r_resp_misalign;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with hand-computed expected values.
module tb_load_unit;
  import load_unit_pkg::*;

  logic   clk = 1'b0;
  logic   reset, flush, req_valid, req_ready, req_unsigned;
  u64     req_addr;
  msize_t req_msize;
  logic   dreq_valid;
  u64     dreq_addr;
  msize_t dreq_size;
  logic   dresp_addr_ok, dresp_data_ok;
  u64     dresp_data;
  logic   resp_valid, resp_ready, resp_misalign;
  u64     resp_data;

  int n_checks = 0;
  int n_errors = 0;

  load_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_msize(req_msize), .req_unsigned(req_unsigned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_misalign(resp_misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [63:0] a, input msize_t m, input logic u);
    req_valid = 1'b1; req_addr = a; req_msize = m; req_unsigned = u;
  endtask

  // Best-case load: accept, addr_ok+data_ok in REQ, result one cycle later.
  task automatic run_fast(input string tag, input logic [63:0] a, input msize_t m,
                          input logic u, input logic [63:0] beat, input logic [63:0] exp);
    present(a, m, u);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    chk({tag, "_dreq_valid"}, {63'd0, dreq_valid}, 64'd1);
    chk({tag, "_dreq_addr"}, dreq_addr, {a[63:3], 3'b000});
    chk({tag, "_dreq_size"}, {62'd0, dreq_size}, 64'd3);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = beat;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_resp_data"}, resp_data, exp);
    chk({tag, "_misalign"}, {63'd0, resp_misalign}, 64'd0);
    chk({tag, "_busy"}, {63'd0, req_ready}, 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_released"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 64'd0;
    req_msize = MSIZE1; req_unsigned = 1'b0; dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = 64'd0; resp_ready = 1'b0;
    step(); step();
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_misalign", {63'd0, resp_misalign}, 64'd0);
    reset = 1'b0;
    step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Extraction / extension cases.
    run_fast("lb",  64'h1007, MSIZE1, 1'b0, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_fast("lbu", 64'h1007, MSIZE1, 1'b1, 64'h80FF_0000_0000_0000, 64'h0000_0000_0000_0080);
    run_fast("lw4", 64'h1004, MSIZE4, 1'b0, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
    run_fast("lw0", 64'h1000, MSIZE4, 1'b0, 64'h8000_0001_1234_5678, 64'h0000_0000_1234_5678);
    run_fast("lwu", 64'h1004, MSIZE4, 1'b1, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001);
    run_fast("lh6", 64'h1006, MSIZE2, 1'b0, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_80FF);
    run_fast("lhu", 64'h1002, MSIZE2, 1'b1, 64'h8000_0001_1234_5678, 64'h0000_0000_0000_1234);
    run_fast("ld",  64'h1008, MSIZE8, 1'b1, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);

    // Misaligned halfword: no bus request, result after one cycle.
    present(64'h1003, MSIZE2, 1'b0);
    step();
    chk("mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("mis_flag", {63'd0, resp_misalign}, 64'd1);
    chk("mis_data", resp_data, 64'd0);
    // Release while a new aligned load is offered: it must not be taken.
    present(64'h4000, MSIZE8, 1'b0);
    resp_ready = 1'b1;
    chk("mis_no_accept_ready", {63'd0, req_ready}, 64'd0);
    step();
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("mis_released", {63'd0, resp_valid}, 64'd0);
    chk("mis_no_accept_bus", {63'd0, dreq_valid}, 64'd0);
    chk("mis_idle", {63'd0, req_ready}, 64'd1);

    // Slow bus: addr_ok after 3 cycles, data_ok 2 cycles later, stalled consumer.
    present(64'h2008, MSIZE8, 1'b0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_dreq_valid", {63'd0, dreq_valid}, 64'd1);
      chk("slow_dreq_addr", dreq_addr, 64'h2008);
      step();
    end
    chk("slow_dreq_valid_last", {63'd0, dreq_valid}, 64'd1);
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    chk("slow_wait_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("slow_wait_resp", {63'd0, resp_valid}, 64'd0);
    step();
    chk("slow_wait_resp2", {63'd0, resp_valid}, 64'd0);
    dresp_data_ok = 1'b1; dresp_data = 64'h0123_4567_89AB_CDEF;
    step();
    dresp_data_ok = 1'b0; dresp_data = 64'd0;
    for (int i = 0; i < 4; i++) begin
      chk("slow_hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("slow_hold_data", resp_data, 64'h0123_4567_89AB_CDEF);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("slow_released", {63'd0, resp_valid}, 64'd0);

    // Flush in WAIT: late data swallowed, ready returns the cycle after data_ok.
    present(64'h3000, MSIZE4, 1'b0);
    step();
    req_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flw_drain_ready", {63'd0, req_ready}, 64'd0);
      chk("flw_drain_resp", {63'd0, resp_valid}, 64'd0);
      step();
    end
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD;
    chk("flw_before_data_ready", {63'd0, req_ready}, 64'd0);
    step();
    dresp_data_ok = 1'b0; dresp_data = 64'd0;
    chk("flw_no_resp", {63'd0, resp_valid}, 64'd0);
    chk("flw_ready_back", {63'd0, req_ready}, 64'd1);

    // Flush in REQ before addr_ok: request held, result discarded.
    present(64'h5000, MSIZE8, 1'b0);
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flr_dreq_held", {63'd0, dreq_valid}, 64'd1);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h1111;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    chk("flr_no_resp", {63'd0, resp_valid}, 64'd0);
    chk("flr_idle", {63'd0, req_ready}, 64'd1);

    // Flush in DONE drops the result.
    present(64'h6000, MSIZE8, 1'b0);
    step();
    req_valid = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h2222;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("fld_valid", {63'd0, resp_valid}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fld_dropped", {63'd0, resp_valid}, 64'd0);

    // Async reset in WAIT.
    present(64'h7000, MSIZE8, 1'b0);
    step();
    req_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    reset = 1'b1;
    #2;
    chk("arw_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("arw_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("arw_resp_data", resp_data, 64'd0);
    reset = 1'b0;
    step();

    // Async reset while a result is held: outputs clear without a clock edge.
    present(64'h8000, MSIZE8, 1'b0);
    step();
    req_valid = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h3333;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    chk("ard_valid_before", {63'd0, resp_valid}, 64'd1);
    reset = 1'b1;
    #2;
    chk("ard_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("ard_resp_data", resp_data, 64'd0);
    reset = 1'b0;
    step();

    run_fast("post_rst", 64'h9001, MSIZE1, 1'b0, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
